// File: rtl/udp_rx_unpack_pkg.sv
// Shared constants and state encoding for the UDP/IPv4 receive unpacker.
`timescale 1ns/1ps
package udp_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_HDR_LEN  = 14;
    localparam int IP_HDR_LEN   = 20;
    localparam int UDP_HDR_LEN  = 8;
    localparam int PREAMBLE_LEN = 7;
    localparam int FCS_LEN      = 4;
    localparam int CNT_W        = 11;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
    } rx_state_e;
endpackage

// File: rtl/udp_rx_unpack_if.sv
// GMII receive byte stream in, unpacked payload words and frame metadata out.
`timescale 1ns/1ps
interface udp_rx_unpack_if;
    logic [7:0]  udp_gmii_rxd;
    logic        udp_gmii_rxv;
    logic [15:0] udp_rx_data;
    logic        udp_rx_en;
    logic        udp_rx_done;
    logic        udp_rx_err;
    logic [15:0] udp_rx_len;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    modport slave (
        input  udp_gmii_rxd, udp_gmii_rxv,
        output udp_rx_data, udp_rx_en, udp_rx_done, udp_rx_err,
        output udp_rx_len, src_mac, src_ip
    );
    modport master (
        output udp_gmii_rxd, udp_gmii_rxv,
        input  udp_rx_data, udp_rx_en, udp_rx_done, udp_rx_err,
        input  udp_rx_len, src_mac, src_ip
    );
endinterface

// File: rtl/rx_crc32_d8.sv
// Byte-wide reflected CRC-32 register; no final inversion, so a good frame leaves the residue.
`timescale 1ns/1ps
module rx_crc32_d8
    import udp_pkg::*;
(
    input  logic        gmii_rxc,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++)
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
    end

    always_ff @(posedge gmii_rxc or negedge rstn) begin
        if (!rstn)      crc_q <= CRC_INIT;
        else if (clr_i) crc_q <= CRC_INIT;
        else if (en_i)  crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/udp_rx_unpack.sv
// UDP/IPv4 receive unpacker: header parse and filter, 16-bit payload packing, FCS check.
`timescale 1ns/1ps
module udp_rx_unpack
    import udp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0164,
    parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
    input  logic           gmii_rxc,
    input  logic           rstn,
    udp_rx_unpack_if.slave bus
);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] ETH_DMAC   = CNT_W'(5);
    localparam logic [CNT_W-1:0] ETH_SMAC   = CNT_W'(11);
    localparam logic [CNT_W-1:0] ETH_LAST   = CNT_W'(ETH_HDR_LEN - 1);
    localparam logic [CNT_W-1:0] IP_PROTO   = CNT_W'(9);
    localparam logic [CNT_W-1:0] IP_SIP     = CNT_W'(15);
    localparam logic [CNT_W-1:0] IP_LAST    = CNT_W'(IP_HDR_LEN - 1);
    localparam logic [CNT_W-1:0] UDP_DPORT  = CNT_W'(3);
    localparam logic [CNT_W-1:0] UDP_ULEN   = CNT_W'(5);
    localparam logic [CNT_W-1:0] UDP_LAST   = CNT_W'(UDP_HDR_LEN - 1);
    localparam logic [CNT_W-1:0] FCS_BYTES  = CNT_W'(FCS_LEN);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rxv_q;
    logic [39:0]      sh_q;
    logic [47:0]      cur;
    logic [47:0]      mac_sh_q;
    logic [31:0]      ip_sh_q;
    logic [15:0]      plen_q;
    logic [7:0]       hi_q;
    logic [15:0]      data_q, len_q;
    logic             en_q, done_q, err_q;
    logic [47:0]      src_mac_q;
    logic [31:0]      src_ip_q;
    logic [15:0]      pay_next;
    logic [31:0]      crc;
    logic             crc_clr, crc_en;
    logic             rxv;
    logic [7:0]       rxd;

    assign rxv      = bus.udp_gmii_rxv;
    assign rxd      = bus.udp_gmii_rxd;
    // Last six bytes including the current one; header fields are compared on their final byte.
    assign cur      = {sh_q, rxd};
    assign pay_next = 16'(cnt_q) + 16'd1;
    assign crc_clr  = (state_q == IDLE);
    assign crc_en   = rxv && (state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL});

    rx_crc32_d8 u_crc (
        .gmii_rxc (gmii_rxc),
        .rstn     (rstn),
        .clr_i    (crc_clr),
        .en_i     (crc_en),
        .data_i   (rxd),
        .crc_o    (crc)
    );

    always_ff @(posedge gmii_rxc or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            // Treat reset as "rxv already high" so a frame in flight at release is skipped.
            rxv_q     <= 1'b1;
            sh_q      <= '0;
            mac_sh_q  <= '0;
            ip_sh_q   <= '0;
            plen_q    <= '0;
            hi_q      <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            src_mac_q <= '0;
            src_ip_q  <= '0;
        end else begin
            rxv_q  <= rxv;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (rxv) sh_q <= cur[39:0];

            unique case (state_q)
                IDLE: begin
                    if (rxv && !rxv_q && rxd == PREAMBLE_BYTE) begin
                        state_q <= PREAMBLE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                PREAMBLE: begin
                    if (!rxv)                                      state_q <= IDLE;
                    else if (rxd == PREAMBLE_BYTE && cnt_q < PRE_LAST) cnt_q <= cnt_q + CNT_W'(1);
                    else if (rxd == SFD_BYTE && cnt_q == PRE_LAST) begin
                        state_q <= ETH_HDR;
                        cnt_q   <= '0;
                    end else                                       state_q <= DROP;
                end
                ETH_HDR: begin
                    if (!rxv) state_q <= IDLE;
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == ETH_DMAC && cur != LOCAL_MAC && cur != '1)
                            state_q <= DROP;
                        else if (cnt_q == ETH_SMAC)
                            mac_sh_q <= cur;
                        else if (cnt_q == ETH_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (cur[15:0] == ETH_TYPE_IPV4) ? IP_HDR : DROP;
                        end
                    end
                end
                IP_HDR: begin
                    if (!rxv) state_q <= IDLE;
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((cnt_q == '0 && rxd != IP_VER_IHL) ||
                            (cnt_q == IP_PROTO && rxd != IP_PROTO_UDP))
                            state_q <= DROP;
                        else if (cnt_q == IP_SIP)
                            ip_sh_q <= cur[31:0];
                        else if (cnt_q == IP_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (cur[31:0] == LOCAL_IP) ? UDP_HDR : DROP;
                        end
                    end
                end
                UDP_HDR: begin
                    if (!rxv) state_q <= IDLE;
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == UDP_DPORT && cur[15:0] != LOCAL_PORT)
                            state_q <= DROP;
                        else if (cnt_q == UDP_ULEN) begin
                            if (cur[15:0] < 16'(UDP_HDR_LEN)) state_q <= DROP;
                            plen_q <= cur[15:0] - 16'(UDP_HDR_LEN);
                        end else if (cnt_q == UDP_LAST) begin
                            // Commit point: metadata becomes visible and stays until the next commit.
                            cnt_q     <= '0;
                            src_mac_q <= mac_sh_q;
                            src_ip_q  <= ip_sh_q;
                            len_q     <= plen_q;
                            state_q   <= (plen_q == '0) ? TAIL : PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!rxv) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!cnt_q[0]) hi_q <= rxd;
                        if (cnt_q[0]) begin
                            data_q <= {hi_q, rxd};
                            en_q   <= 1'b1;
                        end else if (pay_next == len_q) begin
                            data_q <= {rxd, 8'h00};
                            en_q   <= 1'b1;
                        end
                        if (pay_next == len_q) begin
                            cnt_q   <= '0;
                            state_q <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (!rxv) begin
                        state_q <= IDLE;
                        if (cnt_q < FCS_BYTES || crc != CRC_RESIDUE) err_q  <= 1'b1;
                        else                                          done_q <= 1'b1;
                    end else if (cnt_q < FCS_BYTES) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DROP: begin
                    if (!rxv) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.udp_rx_data = data_q;
    assign bus.udp_rx_en   = en_q;
    assign bus.udp_rx_done = done_q;
    assign bus.udp_rx_err  = err_q;
    assign bus.udp_rx_len  = len_q;
    assign bus.src_mac     = src_mac_q;
    assign bus.src_ip      = src_ip_q;
endmodule
